uart_byte_receiver: RTL and testbench
=====================================

// Module: uart_byte_receiver
// PURPOSE
//  Receives 8-bit UART bytes from the raw uart_rx board pin on the 25 MHz plotter clock.
//  Synchronises the pin and deframes start/data/stop bits at the mid-bit point.
//  Buffers received bytes in a small FIFO with a valid/ready interface to the command parser.
//  Sits between the uart_rx top-level pin and the plotter command path.
// PARAMETERS
//  CLK_FREQ_HZ   25000000  clk frequency in Hz
//  BAUD_RATE     115200    line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer div, 217 at defaults)
//  FIFO_DEPTH    4         byte FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1  system clock (25 MHz)
//  reset      in   1  asynchronous, active-high reset
//  uart_rx    in   1  raw serial line; idle high; 8N1, LSB first
//  rx_data    out  8  FIFO head byte; valid only while rx_valid=1
//  rx_valid   out  1  FIFO non-empty
//  rx_ready   in   1  consumer accepts; pop when rx_valid && rx_ready
//  rx_busy    out  1  deframer not in IDLE
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  overrun    out  1  1-cycle pulse: byte completed while FIFO full and no pop that cycle
//  parity_err out  1  1-cycle pulse: parity mismatch (constant 0 without the macro)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high: clk, reset as above.
//  - Reset: 2-FF sync regs =1, state IDLE, FIFO empty, rx_valid=0, rx_data=0, rx_busy=0,
//    frame_err=overrun=parity_err=0, bit counter and tick counter =0. Reset mid-byte abandons the byte.
//  - uart_rx passes through a 2-FF synchroniser (rxs); all decisions use rxs only.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; BREAK on framing error.
//    IDLE: rxs==0 -> START, tick counter cleared.
//    START: after CLKS_PER_BIT/2 cycles sample rxs; 1 -> IDLE (glitch, no flags); 0 -> DATA.
//    DATA: every CLKS_PER_BIT cycles sample rxs into shift reg LSB first; after 8th sample -> STOP
//          (or PARITY when macro set).
//    STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> push byte, -> IDLE the same cycle
//          (mid-stop-bit, so back-to-back frames are caught); 0 -> frame_err pulse, byte dropped, -> BREAK.
//    BREAK: wait for rxs==1, then -> IDLE; no start detection while line held low.
//  - Push latency: byte visible on rx_data/rx_valid the cycle after the stop-bit sample cycle.
//  - FIFO: first-word-fall-through; rx_data = head; pop advances head next cycle.
//    Push while full with no pop same cycle: byte dropped, overrun pulse, contents unchanged.
//    Push and pop same cycle when full: both happen, no overrun, count unchanged.
//    Push and pop same cycle when empty: not possible (rx_valid=0); pushed byte becomes head.
//    Read/write pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  - Flags are registered single-cycle pulses; at most one of frame_err/parity_err/overrun per frame.
// CONFIGURATION
//  Macro UART_RX_PARITY_EN:
//  - Defined: frame is 8E1; PARITY state samples one extra bit after data, CLKS_PER_BIT later.
//    Mismatch vs even parity of the 8 data bits -> parity_err pulse at the stop-bit sample cycle,
//    byte dropped (no push, no overrun); stop-bit check still applies (frame_err takes precedence).
//  - Undefined: 8N1, no PARITY state, parity_err tied 0.
// TESTING (defaults: 217 clk/bit, FIFO_DEPTH=4)
//  1 rx_ready=1, send 0xA5 8N1 -> rx_valid high 1 cycle with rx_data=0xA5, ~2061 clks after start edge.
//  2 Low glitch of 50 clks on idle line -> START aborts at 108 clks, no valid, no flags, rx_busy back to 0.
//  3 Send 0x3C with stop bit 0, then hold line low 20 bit times -> one frame_err pulse, no valid, no further bytes;
//    line high then 0x11 -> received 0x11.
//  4 rx_ready=0, send 0x01..0x05 back-to-back -> one overrun at 5th byte; then rx_ready=1 pops 0x01,0x02,0x03,0x04 in order.
//  5 Assert reset mid-byte (after 4 data bits) -> all outputs at reset values next cycle;
//    after release, 0x5A received correctly.
//  6 UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no valid; 0x07 with parity 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined): 2-FF pin sync, mid-bit deframing,
// first-word-fall-through byte FIFO with valid/ready output; byte visible the cycle after the stop sample.
module uart_byte_receiver #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          r_state, w_next;
  logic            r_sync1, r_sync2;
  logic [TW-1:0]   r_tick;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_frame_err, r_overrun, r_parity_err;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count;

  logic            w_rxs, w_tick_done, w_sample_data;
  logic            w_push, w_frame_err, w_parity_err;
  logic            w_full, w_empty, w_pop, w_wr_en;

`ifdef UART_RX_PARITY_EN
  logic            r_par;
  logic            w_sample_par;
  logic            w_par_bad;
  assign w_par_bad = ^{r_shift, r_par};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // START samples at half a bit so every later sample lands mid-bit.
  assign w_tick_done = (r_state == S_START) ? (r_tick == TW'(HALF_BIT - 1))
                                            : (r_tick == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    w_parity_err  = 1'b0;
    w_sample_data = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_sample_par  = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (!w_rxs) w_next = S_START;
      S_START: if (w_tick_done) w_next = w_rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick_done) begin
          w_sample_data = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit == 3'd7) w_next = S_PARITY;
`else
          if (r_bit == 3'd7) w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick_done) begin
          w_sample_par = 1'b1;
          w_next       = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick_done) begin
          if (!w_rxs) begin
            w_frame_err = 1'b1;
            w_next      = S_BREAK;
          end else begin
            w_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (w_par_bad) w_parity_err = 1'b1;
            else           w_push       = 1'b1;
`else
            w_push = 1'b1;
`endif
          end
        end
      end
      S_BREAK: if (w_rxs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE || r_state == S_BREAK || w_tick_done) r_tick <= '0;
      else                                                         r_tick <= r_tick + 1'b1;
      if (r_state == S_START)  r_bit <= '0;
      else if (w_sample_data)  r_bit <= r_bit + 1'b1;
      if (w_sample_data) r_shift <= {w_rxs, r_shift[7:1]};
`ifdef UART_RX_PARITY_EN
      if (w_sample_par) r_par <= w_rxs;
`endif
    end
  end

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      r_overrun    <= w_push && w_full && !w_pop;
    end
  end

  assign rx_valid   = !w_empty;
  assign rx_data    = w_empty ? 8'h00 : r_mem[r_rd];
  assign rx_busy    = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_byte_receiver.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_byte_receiver: stimulus queues expected bytes, a negedge monitor pops and compares.
module tb_uart_byte_receiver;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_fe = 0, n_ov = 0, n_pe = 0, busy_cnt = 0;
  int last_pop_cyc = 0;
  int t0;
  logic [7:0] exp_q[$];

  uart_byte_receiver dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err)  n_fe++;
      if (overrun)    n_ov++;
      if (parity_err) n_pe++;
      if (rx_busy)    busy_cnt++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL byte_data: got %02h expected %02h", rx_data, e);
          end
          last_pop_cyc = cyc;
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_busy", rx_busy, 0);
    check("reset_flags", {frame_err, overrun, parity_err}, 3'b000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single byte, exact latency from the pin edge
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("t1_drain");
    check("t1_latency", last_pop_cyc - t0, 2064);
    repeat (CPB) @(negedge clk);

    // 2: 50-clock glitch aborts START after half a bit
    busy_cnt = 0;
    uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_busy_mid", rx_busy, 1);
    repeat (200) @(negedge clk);
    check("t2_busy_len", busy_cnt, 108);
    check("t2_busy_end", rx_busy, 0);
    check("t2_no_flags", n_fe + n_ov + n_pe, 0);

    // 3: framing error then break, recovery with 0x11
    send_frame(8'h3C, 1'b0);
    uart_rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("t3_frame_err", n_fe, 1);
    check("t3_busy_break", rx_busy, 1);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t3_busy_idle", rx_busy, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_drain("t3_drain");
    check("t3_frame_err_once", n_fe, 1);

    // 4: overrun on fifth byte with consumer stalled
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    repeat (CPB) @(negedge clk);
    check("t4_overrun", n_ov, 1);
    check("t4_valid_full", rx_valid, 1);
    check("t4_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    wait_drain("t4_drain");
    @(negedge clk);
    check("t4_empty", rx_valid, 0);

    // 5: reset mid-byte clears FIFO and deframer
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    repeat (CPB) @(negedge clk);
    check("t5_pre_valid", rx_valid, 1);
    check("t5_pre_data", rx_data, 8'h77);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_busy", rx_busy, 0);
    check("t5_rst_flags", {frame_err, overrun, parity_err}, 3'b000);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_ready = 1'b1;
    repeat (CPB) @(negedge clk);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_drain("t5_drain");

`ifdef UART_RX_PARITY_EN
    // 6: wrong then correct even parity on 0x07
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (CPB) @(negedge clk);
    check("t6_parity_err", n_pe, 1);
    exp_q.push_back(8'h07);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_drain("t6_drain");
    check("t6_parity_err_once", n_pe, 1);
`else
    check("no_parity_err", n_pe, 0);
`endif
    check("final_frame_err", n_fe, 1);
    check("final_overrun", n_ov, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_800_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
